// File: rtl/bcd_timer_core.sv
// bcd_timer_core
//   Multi-field BCD stopwatch / countdown core. NUM_PAIRS two-digit BCD fields
//   (pair0 least significant) count up with carry or down with borrow on each
//   tick_in pulse. The core also provides preset load, per-field adjust, a
//   latched zero alarm gated onto a tone, and a 4-digit display window.
//   Every lower pair counts mod 60. The top pair counts mod TOP_MOD.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   i_tick_in         count enable pulse (one clk wide)
//   i_tick_adj        adjust-rate pulse (one clk wide)
//   i_tone            alarm tone square wave
//   i_start/i_pause   set running / toggle running (start wins if both)
//   i_dir             1 = up, 0 = down
//   i_adj, i_adj_sel  adjust mode level, and the pair it steps
//   i_load/i_load_val preset pulse and BCD preset (pair k at [8k+7:8k])
//   i_view            lower pair index of the display window
//   i_alarm_clr       clear the latched alarm
//   o_digits          current count, same packing as i_load_val
//   o_disp            {pair[v+1], pair[v]}, v = min(view, NUM_PAIRS-2)
//   o_running         counter active
//   o_alarm           countdown reached zero (latched)
//   o_sound_out       alarm & tone
module bcd_timer_core #(
  parameter int NUM_PAIRS = 3,
  parameter int TOP_MOD   = 24,
  parameter int PSEL_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_tick_in,
  input  logic                   i_tick_adj,
  input  logic                   i_tone,
  input  logic                   i_start,
  input  logic                   i_pause,
  input  logic                   i_dir,
  input  logic                   i_adj,
  input  logic [PSEL_W-1:0]      i_adj_sel,
  input  logic                   i_load,
  input  logic [8*NUM_PAIRS-1:0] i_load_val,
  input  logic [PSEL_W-1:0]      i_view,
  input  logic                   i_alarm_clr,
  output logic [8*NUM_PAIRS-1:0] o_digits,
  output logic [15:0]            o_disp,
  output logic                   o_running,
  output logic                   o_alarm,
  output logic                   o_sound_out
);

  function automatic int pair_mod(input int k);
    return (k == NUM_PAIRS-1) ? TOP_MOD : 60;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  // BCD step helpers: tens and units change together, so no intermediate
  // non-BCD value is ever registered.
  function automatic logic [7:0] bcd_inc(input logic [7:0] p, input int k);
    if (p == to_bcd(pair_mod(k) - 1)) return 8'h00;
    if (p[3:0] == 4'd9)               return {p[7:4] + 4'd1, 4'd0};
    return {p[7:4], p[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] p, input int k);
    if (p == 8'h00)      return to_bcd(pair_mod(k) - 1);
    if (p[3:0] == 4'd0)  return {p[7:4] - 4'd1, 4'd9};
    return {p[7:4], p[3:0] - 4'd1};
  endfunction

  // A preset field with a non-BCD nibble, or a value at or above its modulus,
  // loads 00.
  function automatic logic [7:0] load_field(input logic [7:0] f, input int k);
    if (f[7:4] > 4'd9 || f[3:0] > 4'd9) return 8'h00;
    if (int'(f[7:4]) * 10 + int'(f[3:0]) >= pair_mod(k)) return 8'h00;
    return f;
  endfunction

  logic [7:0]  r_pair     [NUM_PAIRS];
  logic [7:0]  w_pair_nxt [NUM_PAIRS];
  logic        r_running, w_running_nxt;
  logic        r_alarm, w_alarm_nxt, w_alarm_set;
  logic        r_sound;
  logic [15:0] r_disp, w_disp;
  logic        w_cur_zero, w_nxt_zero, w_carry;
  int          w_view;

  // Priority: load > adj > start/pause > tick_in.
  always_comb begin
    // NOTE: every variable gets a default up front, so no path leaves one unassigned and no latch is inferred.
    w_pair_nxt    = r_pair;
    w_running_nxt = r_running;
    w_alarm_set   = 1'b0;
    w_carry       = 1'b1;
    w_nxt_zero    = 1'b0;
    w_cur_zero    = 1'b1;
    for (int k = 0; k < NUM_PAIRS; k++)
      if (r_pair[k] != 8'h00) w_cur_zero = 1'b0;

    if (i_load) begin
      for (int k = 0; k < NUM_PAIRS; k++)
        w_pair_nxt[k] = load_field(i_load_val[8*k +: 8], k);
      w_running_nxt = 1'b0;
    end else if (i_adj) begin
      w_running_nxt = 1'b0;
      // Adjust steps one pair only. There is no carry into its neighbours.
      if (i_tick_adj)
        for (int k = 0; k < NUM_PAIRS; k++)
          if (int'(i_adj_sel) == k) w_pair_nxt[k] = bcd_inc(r_pair[k], k);
    end else if (i_start) begin
      w_running_nxt = 1'b1;
    end else if (i_pause) begin
      w_running_nxt = !r_running;
    end else if (r_running && i_tick_in) begin
      if (i_dir) begin
        // Ripple carry: each pair steps only if every lower pair wrapped.
        for (int k = 0; k < NUM_PAIRS; k++)
          if (w_carry) begin
            w_pair_nxt[k] = bcd_inc(r_pair[k], k);
            w_carry       = (r_pair[k] == to_bcd(pair_mod(k) - 1));
          end
      end else if (w_cur_zero) begin
        // Already at zero: raise the alarm and stop rather than wrap.
        w_alarm_set   = 1'b1;
        w_running_nxt = 1'b0;
      end else begin
        for (int k = 0; k < NUM_PAIRS; k++)
          if (w_carry) begin
            w_pair_nxt[k] = bcd_dec(r_pair[k], k);
            w_carry       = (r_pair[k] == 8'h00);
          end
        w_nxt_zero = 1'b1;
        for (int k = 0; k < NUM_PAIRS; k++)
          if (w_pair_nxt[k] != 8'h00) w_nxt_zero = 1'b0;
        if (w_nxt_zero) begin
          w_alarm_set   = 1'b1;
          w_running_nxt = 1'b0;
        end
      end
    end

    // A new alarm beats a simultaneous clear. Load always clears.
    if (i_load)           w_alarm_nxt = 1'b0;
    else if (w_alarm_set) w_alarm_nxt = 1'b1;
    else if (i_alarm_clr) w_alarm_nxt = 1'b0;
    else                  w_alarm_nxt = r_alarm;
  end

  // The display window is clamped so the upper half never leaves the pair array.
  always_comb begin
    w_view = (int'(i_view) > NUM_PAIRS-2) ? NUM_PAIRS-2 : int'(i_view);
    w_disp = {r_pair[1], r_pair[0]};
    for (int k = 0; k < NUM_PAIRS-1; k++)
      if (k == w_view) w_disp = {r_pair[k+1], r_pair[k]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: r_pair is a handful of flops, not a RAM, so it sits under the async reset like any other state.
      for (int k = 0; k < NUM_PAIRS; k++) r_pair[k] <= 8'h00;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
      r_sound   <= 1'b0;
      r_disp    <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments let every register sample the pre-edge values, whatever the statement order.
      r_pair    <= w_pair_nxt;
      r_running <= w_running_nxt;
      r_alarm   <= w_alarm_nxt;
      r_sound   <= r_alarm & i_tone;
      r_disp    <= w_disp;
    end
  end

  for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_pack
    assign o_digits[8*g +: 8] = r_pair[g];
  end

  assign o_disp      = r_disp;
  assign o_running   = r_running;
  assign o_alarm     = r_alarm;
  assign o_sound_out = r_sound;

endmodule

// File: tb/tb_bcd_timer_core.sv
// tb_bcd_timer_core
//   Self-checking bench for bcd_timer_core (3 pairs, top pair mod 24).
//   A table of single-cycle vectors covers the main counting, load, adjust and
//   alarm cases. Hand sequences cover the display window, sound gating and
//   asynchronous reset. A randomized phase compares every output against a
//   reference model. The model keeps the count as a single mixed-radix
//   integer (60 * 60 * 24 states).
module tb_bcd_timer_core;

  localparam int NP    = 3;
  localparam int TOP   = 24;
  localparam int RANGE = 60 * 60 * TOP;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_in, tick_adj, tone, start, pause, dir, adj, load, alarm_clr;
  logic [1:0]  adj_sel, view;
  logic [23:0] load_val;
  logic [23:0] digits;
  logic [15:0] disp;
  logic        running, alarm, sound_out;

  int n_checks = 0;
  int n_errors = 0;

  bcd_timer_core #(.NUM_PAIRS(NP), .TOP_MOD(TOP), .PSEL_W(2)) dut (
    .clk(clk), .rst(rst),
    .i_tick_in(tick_in), .i_tick_adj(tick_adj), .i_tone(tone),
    .i_start(start), .i_pause(pause), .i_dir(dir), .i_adj(adj),
    .i_adj_sel(adj_sel), .i_load(load), .i_load_val(load_val),
    .i_view(view), .i_alarm_clr(alarm_clr),
    .o_digits(digits), .o_disp(disp), .o_running(running),
    .o_alarm(alarm), .o_sound_out(sound_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_n;
  bit          m_run, m_alarm, m_sound;
  logic [15:0] m_disp;

  function automatic int fmod(input int k);
    return (k == NP-1) ? TOP : 60;
  endfunction

  function automatic int weight(input int k);
    int w = 1;
    for (int j = 0; j < k; j++) w *= 60;
    return w;
  endfunction

  function automatic int field(input int n, input int k);
    return (n / weight(k)) % fmod(k);
  endfunction

  function automatic logic [23:0] pack(input int n);
    logic [23:0] r = '0;
    for (int k = 0; k < NP; k++) begin
      int v;
      v = field(n, k);
      r[8*k +: 8] = {4'(v / 10), 4'(v % 10)};
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_n = 0; m_run = 0; m_alarm = 0; m_sound = 0; m_disp = '0;
  endfunction

  // Advances the model by one clock edge using the currently driven inputs.
  function automatic void model_step();
    logic [23:0] old;
    int          v, f, nf;
    bit          set;
    old = pack(m_n);
    v   = (int'(view) > NP-2) ? NP-2 : int'(view);
    set = 0;
    m_disp  = {old[8*(v+1) +: 8], old[8*v +: 8]};
    m_sound = m_alarm & tone;
    if (load) begin
      m_n = 0;
      for (int k = 0; k < NP; k++) begin
        int t, u;
        t = int'(load_val[8*k+4 +: 4]);
        u = int'(load_val[8*k +: 4]);
        if (t <= 9 && u <= 9 && t*10 + u < fmod(k)) m_n += (t*10 + u) * weight(k);
      end
      m_run   = 0;
      m_alarm = 0;
    end else begin
      if (adj) begin
        m_run = 0;
        if (tick_adj && int'(adj_sel) < NP) begin
          f   = field(m_n, int'(adj_sel));
          nf  = (f + 1) % fmod(int'(adj_sel));
          m_n = m_n + (nf - f) * weight(int'(adj_sel));
        end
      end else if (start) m_run = 1;
      else if (pause)     m_run = !m_run;
      else if (m_run && tick_in) begin
        if (dir) m_n = (m_n + 1) % RANGE;
        else if (m_n == 0) begin set = 1; m_run = 0; end
        else begin
          m_n--;
          if (m_n == 0) begin set = 1; m_run = 0; end
        end
      end
      if (set)            m_alarm = 1;
      else if (alarm_clr) m_alarm = 0;
    end
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tick_in = 0; tick_adj = 0; tone = 0; start = 0; pause = 0; adj = 0;
    adj_sel = 0; load = 0; load_val = '0; view = 0; alarm_clr = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, " digits"},  32'(digits),    32'(pack(m_n)));
    check({tag, " running"}, 32'(running),   32'(m_run));
    check({tag, " alarm"},   32'(alarm),     32'(m_alarm));
    check({tag, " disp"},    32'(disp),      32'(m_disp));
    check({tag, " sound"},   32'(sound_out), 32'(m_sound));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ld;
    logic [23:0] lv;
    logic        dr, st, pa, tk, ad;
    logic [1:0]  asel;
    logic        tadj, clr;
    logic [23:0] ed;
    logic        er, ea;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic ld, input logic [23:0] lv, input logic dr,
                              input logic st, input logic pa, input logic tk,
                              input logic ad, input logic [1:0] asel, input logic tadj,
                              input logic clr, input logic [23:0] ed,
                              input logic er, input logic ea);
    vec_t v;
    v.ld = ld; v.lv = lv; v.dr = dr; v.st = st; v.pa = pa; v.tk = tk; v.ad = ad;
    v.asel = asel; v.tadj = tadj; v.clr = clr; v.ed = ed; v.er = er; v.ea = ea;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    idle_inputs();
    dir = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check("reset digits",  32'(digits),    32'h0);
    check("reset disp",    32'(disp),      32'h0);
    check("reset running", 32'(running),   32'h0);
    check("reset alarm",   32'(alarm),     32'h0);
    check("reset sound",   32'(sound_out), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    //            ld lv          dr st pa tk ad sel ta cl  digits     run al
    vq.push_back(mk(1, 24'h005959, 1, 0, 0, 0, 0, 0, 0, 0, 24'h005959, 0, 0));
    vq.push_back(mk(0, 24'h0,      1, 1, 0, 0, 0, 0, 0, 0, 24'h005959, 1, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 0, 1, 0, 0, 0, 0, 24'h010000, 1, 0));
    vq.push_back(mk(1, 24'h235959, 1, 0, 0, 0, 0, 0, 0, 0, 24'h235959, 0, 0));
    vq.push_back(mk(0, 24'h0,      1, 1, 0, 0, 0, 0, 0, 0, 24'h235959, 1, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 0, 1, 0, 0, 0, 0, 24'h000000, 1, 0));
    vq.push_back(mk(1, 24'h000002, 0, 0, 0, 0, 0, 0, 0, 0, 24'h000002, 0, 0));
    vq.push_back(mk(0, 24'h0,      0, 1, 0, 0, 0, 0, 0, 0, 24'h000002, 1, 0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 1, 0, 0, 0, 0, 24'h000001, 1, 0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 1, 0, 0, 0, 0, 24'h000000, 0, 1));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 0, 0, 0, 0, 1, 24'h000000, 0, 0));
    vq.push_back(mk(1, 24'h001000, 1, 0, 0, 0, 0, 0, 0, 0, 24'h001000, 0, 0));
    vq.push_back(mk(0, 24'h0,      1, 1, 0, 0, 0, 0, 0, 0, 24'h001000, 1, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 0, 1, 0, 0, 0, 0, 24'h001001, 1, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 1, 0, 0, 0, 0, 0, 24'h001001, 0, 0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 24'h0,    1, 0, 0, 1, 0, 0, 0, 0, 24'h001001, 0, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 1, 0, 0, 0, 0, 0, 24'h001001, 1, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 0, 1, 0, 0, 0, 0, 24'h001002, 1, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 1, 0, 0, 0, 0, 0, 24'h001002, 0, 0));
    vq.push_back(mk(0, 24'h0,      1, 1, 1, 0, 0, 0, 0, 0, 24'h001002, 1, 0));
    vq.push_back(mk(1, 24'h005930, 1, 0, 0, 0, 0, 0, 0, 0, 24'h005930, 0, 0));
    vq.push_back(mk(0, 24'h0,      1, 1, 0, 0, 0, 0, 0, 0, 24'h005930, 1, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 0, 0, 1, 1, 1, 0, 24'h000030, 0, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 0, 1, 1, 1, 0, 0, 24'h000030, 0, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 0, 0, 1, 3, 1, 0, 24'h000030, 0, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 0, 0, 1, 2, 1, 0, 24'h010030, 0, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 0, 0, 1, 0, 1, 0, 24'h010031, 0, 0));
    vq.push_back(mk(1, 24'h00607A, 1, 0, 0, 0, 0, 0, 0, 0, 24'h000000, 0, 0));
    vq.push_back(mk(1, 24'h234512, 1, 0, 0, 0, 0, 0, 0, 0, 24'h234512, 0, 0));
    vq.push_back(mk(1, 24'h244512, 1, 0, 0, 0, 0, 0, 0, 0, 24'h004512, 0, 0));
    vq.push_back(mk(1, 24'h000000, 0, 0, 0, 0, 0, 0, 0, 0, 24'h000000, 0, 0));
    vq.push_back(mk(0, 24'h0,      0, 1, 0, 0, 0, 0, 0, 0, 24'h000000, 1, 0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 1, 0, 0, 0, 0, 24'h000000, 0, 1));
    vq.push_back(mk(1, 24'h000001, 0, 0, 0, 0, 0, 0, 0, 0, 24'h000001, 0, 0));
    vq.push_back(mk(0, 24'h0,      0, 1, 0, 0, 0, 0, 0, 0, 24'h000001, 1, 0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 1, 0, 0, 0, 1, 24'h000000, 0, 1));

    foreach (vq[i]) begin
      load = vq[i].ld; load_val = vq[i].lv; dir = vq[i].dr; start = vq[i].st;
      pause = vq[i].pa; tick_in = vq[i].tk; adj = vq[i].ad; adj_sel = vq[i].asel;
      tick_adj = vq[i].tadj; alarm_clr = vq[i].clr;
      cycle();
      check($sformatf("vec%0d digits", i),  32'(digits),  32'(vq[i].ed));
      check($sformatf("vec%0d running", i), 32'(running), 32'(vq[i].er));
      check($sformatf("vec%0d alarm", i),   32'(alarm),   32'(vq[i].ea));
    end
    idle_inputs();

    // Display window and clamping of view.
    load = 1; load_val = 24'h234512; cycle();
    load = 0; view = 2; cycle();
    check("disp view2 clamped", 32'(disp), 32'h2345);
    view = 0; cycle();
    check("disp view0", 32'(disp), 32'h4512);
    view = 3; cycle();
    check("disp view3 clamped", 32'(disp), 32'h2345);
    view = 0;

    // Sound follows tone one clock late while the alarm is latched.
    dir = 0; load = 1; load_val = 24'h000001; cycle();
    load = 0; start = 1; cycle();
    start = 0; tick_in = 1; cycle();
    tick_in = 0;
    check("sound alarm set", 32'(alarm), 32'h1);
    tone = 1; cycle();
    check("sound tone hi", 32'(sound_out), 32'h1);
    tone = 0; cycle();
    check("sound tone lo", 32'(sound_out), 32'h0);
    tone = 1; alarm_clr = 1; cycle();
    check("sound clr alarm", 32'(alarm), 32'h0);
    check("sound clr lag", 32'(sound_out), 32'h1);
    alarm_clr = 0; cycle();
    check("sound after clr", 32'(sound_out), 32'h0);
    check_model("post-seq");

    // Randomized phase against the model.
    for (int c = 0; c < 3000; c++) begin
      load = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 0) load_val = 24'($urandom_range(0, 3));
      else
        for (int k = 0; k < NP; k++)
          load_val[8*k +: 8] = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                               : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 39) == 0) dir = !dir;
      if ($urandom_range(0, 49) == 0) adj = !adj;
      start     = ($urandom_range(0, 29) == 0);
      pause     = ($urandom_range(0, 29) == 0);
      tick_in   = ($urandom_range(0, 1) == 0);
      tick_adj  = ($urandom_range(0, 2) == 0);
      adj_sel   = 2'($urandom_range(0, 3));
      alarm_clr = ($urandom_range(0, 19) == 0);
      view      = 2'($urandom_range(0, 3));
      tone      = 1'($urandom_range(0, 1));
      cycle();
      check_model($sformatf("rand%0d", c));
    end
    idle_inputs();

    // Asynchronous reset mid-count, then counting restarts from zero.
    dir = 1; load = 1; load_val = 24'h001000; cycle();
    load = 0; start = 1; cycle();
    start = 0; tick_in = 1; cycle(); cycle();
    tick_in = 0; view = 1; cycle();
    #2 rst = 1'b1;
    #1;
    check("async rst digits",  32'(digits),    32'h0);
    check("async rst disp",    32'(disp),      32'h0);
    check("async rst running", 32'(running),   32'h0);
    check("async rst alarm",   32'(alarm),     32'h0);
    check("async rst sound",   32'(sound_out), 32'h0);
    #1 rst = 1'b0;
    model_reset();
    idle_inputs();
    dir = 1; start = 1; cycle();
    start = 0; tick_in = 1; cycle();
    tick_in = 0;
    check("after rst first tick", 32'(digits), 32'h000001);
    check_model("after rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
